// File: rtl/bus_timer_responder_pkg.sv
// Shared definitions for the bus timer responder: register offsets, bit positions,
// FSM encoding and the default window base.
package bus_timer_responder_pkg;

  localparam logic [31:0] TMR_DEFAULT_BASE = 32'hFFFF_0100;

  localparam logic [4:0] TMR_CTRL    = 5'h00;
  localparam logic [4:0] TMR_COUNT   = 5'h04;
  localparam logic [4:0] TMR_COMPARE = 5'h08;
  localparam logic [4:0] TMR_STATUS  = 5'h0C;
  localparam logic [4:0] TMR_CAPTURE = 5'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_CIE    = 3;
  localparam int CTRL_PS_LSB = 16;

  localparam int STAT_MATCH = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_CAPF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/bus_timer_responder_bus_byte_merge.sv
// Per-lane write merge: each enabled byte lane takes the write data, the rest keep
// the old register value.
module bus_byte_merge (
  input  logic [31:0] old_val,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped prescaled timer on the Dw* data bus with compare match and level IRQ.
// Optional capture input enabled by defining BUS_TIMER_CAPTURE_EN.
//   state | meaning
//   IDLE  | stopped, waiting for CTRL.EN
//   RUN   | counting prescaled ticks toward COMPARE
//   HALT  | one-shot matched, DONE held until EN or COUNT is rewritten
module bus_timer_responder
  import bus_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TMR_DEFAULT_BASE,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        iCLK,
  input  logic        iRST,
`ifdef BUS_TIMER_CAPTURE_EN
  input  logic        iCapture,
`endif
  input  logic        DwReadEnable,
  input  logic        DwWriteEnable,
  input  logic [3:0]  DwByteEnable,
  input  logic [31:0] DwAddress,
  input  logic [31:0] DwWriteData,
  output logic [31:0] oReadData,
  output logic        oHit,
  output logic        oIRQ
);

  logic             en_q, en_d, reload_q, reload_d, ie_q, ie_d;
  logic [15:0]      prescale_q, prescale_d, ps_q, ps_d;
  logic [CNT_W-1:0] count_q, count_d, compare_q, compare_d;
  logic             match_q, match_d, done_q, done_d, irq_q, irq_d;
  tmr_state_e       state_q, state_d;

  logic [4:0]  offset;
  logic        wr_hit, wr_ctrl, wr_count, wr_compare, wr_status;
  logic        tick, match_set, cie_bit, capf_bit;
  logic [31:0] ctrl_rd, count_rd, compare_rd, status_rd, capture_rd, rd_sel;
  logic [31:0] ctrl_wv, count_wv, compare_wv, status_wv;

  assign oHit       = (DwAddress[31:5] == BASE_ADDR[31:5]);
  assign offset     = {DwAddress[4:2], 2'b00};
  assign wr_hit     = DwWriteEnable & oHit;
  assign wr_ctrl    = wr_hit & (offset == TMR_CTRL);
  assign wr_count   = wr_hit & (offset == TMR_COUNT);
  assign wr_compare = wr_hit & (offset == TMR_COMPARE);
  assign wr_status  = wr_hit & (offset == TMR_STATUS);

  always_comb begin
    count_rd   = '0;
    compare_rd = '0;
    count_rd[CNT_W-1:0]   = count_q;
    compare_rd[CNT_W-1:0] = compare_q;
  end

  assign ctrl_rd   = {prescale_q, 12'd0, cie_bit, ie_q, reload_q, en_q};
  assign status_rd = {29'd0, capf_bit, done_q, match_q};

  // STATUS merges against zero so the result is the write-1-to-clear mask.
  bus_byte_merge u_merge_ctrl    (.old_val(ctrl_rd),    .wdata(DwWriteData), .be(DwByteEnable), .merged(ctrl_wv));
  bus_byte_merge u_merge_count   (.old_val(count_rd),   .wdata(DwWriteData), .be(DwByteEnable), .merged(count_wv));
  bus_byte_merge u_merge_compare (.old_val(compare_rd), .wdata(DwWriteData), .be(DwByteEnable), .merged(compare_wv));
  bus_byte_merge u_merge_status  (.old_val(32'd0),      .wdata(DwWriteData), .be(DwByteEnable), .merged(status_wv));

  always_comb begin
    case (offset)
      TMR_CTRL:    rd_sel = ctrl_rd;
      TMR_COUNT:   rd_sel = count_rd;
      TMR_COMPARE: rd_sel = compare_rd;
      TMR_STATUS:  rd_sel = status_rd;
      TMR_CAPTURE: rd_sel = capture_rd;
      default:     rd_sel = '0;
    endcase
  end

  assign oReadData = (DwReadEnable && oHit && !iRST) ? rd_sel : 32'd0;
  assign oIRQ      = irq_q;
  assign tick      = (state_q == ST_RUN) && (ps_q >= prescale_q);

  always_comb begin
    en_d       = en_q;
    reload_d   = reload_q;
    ie_d       = ie_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    done_d     = done_q;
    state_d    = state_q;
    ps_d       = '0;
    match_set  = 1'b0;

    if (wr_ctrl) begin
      en_d       = ctrl_wv[CTRL_EN];
      reload_d   = ctrl_wv[CTRL_RELOAD];
      ie_d       = ctrl_wv[CTRL_IE];
      prescale_d = ctrl_wv[CTRL_PS_LSB +: 16];
    end
    if (wr_compare) compare_d = compare_wv[CNT_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (en_d) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_d) begin
          state_d = ST_IDLE;
        end else begin
          ps_d = tick ? 16'd0 : ps_q + 16'd1;
          if (tick) begin
            if (count_q == compare_q) begin
              match_set = 1'b1;
              if (reload_q) begin
                count_d = '0;
              end else begin
                en_d    = 1'b0;
                done_d  = 1'b1;
                state_d = ST_HALT;
              end
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      ST_HALT: begin
        if (en_d) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
        end else if (wr_ctrl || wr_count) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bus write to COUNT overrides whatever the tick would have done.
    if (wr_count) count_d = count_wv[CNT_W-1:0];

    match_d = (match_q & ~(wr_status & status_wv[STAT_MATCH])) | match_set;
    irq_d   = (match_q & ie_q) | (capf_bit & cie_bit);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      en_q       <= 1'b0;
      reload_q   <= 1'b0;
      ie_q       <= 1'b0;
      prescale_q <= '0;
      ps_q       <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      en_q       <= en_d;
      reload_q   <= reload_d;
      ie_q       <= ie_d;
      prescale_q <= prescale_d;
      ps_q       <= ps_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

`ifdef BUS_TIMER_CAPTURE_EN
  logic             cie_q, cie_d, capf_q, capf_d, cap_edge;
  logic [CNT_W-1:0] capture_q, capture_d;
  logic [2:0]       sync_q, sync_d;

  always_comb begin
    sync_d    = {sync_q[1:0], iCapture};
    cap_edge  = sync_q[1] & ~sync_q[2];
    cie_d     = wr_ctrl ? ctrl_wv[CTRL_CIE] : cie_q;
    capture_d = cap_edge ? count_q : capture_q;
    capf_d    = (capf_q & ~(wr_status & status_wv[STAT_CAPF])) | cap_edge;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_q    <= '0;
      cie_q     <= 1'b0;
      capture_q <= '0;
      capf_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cie_q     <= cie_d;
      capture_q <= capture_d;
      capf_q    <= capf_d;
    end
  end

  assign cie_bit  = cie_q;
  assign capf_bit = capf_q;
  always_comb begin
    capture_rd = '0;
    capture_rd[CNT_W-1:0] = capture_q;
  end
`else
  assign cie_bit    = 1'b0;
  assign capf_bit   = 1'b0;
  assign capture_rd = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{DwAddress[1:0], ctrl_wv, count_wv, compare_wv, status_wv};

endmodule
